// File: rtl/tetris_timing_pkg.sv
// Shared timing definitions for the Tetris drop/lock scheduling path.
//
// Contents:
//   TICK_W             width of the tick timer's sec count
//   LOCK_TICKS_DEFAULT ticks a blocked piece waits before it is locked
//   state_t            drop_scheduler state encoding
//   level_thr()        ticks-per-row table indexed by speed level
package tetris_timing_pkg;

  localparam int TICK_W             = 3;
  localparam int LOCK_TICKS_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    CLR      = 3'd2,
    LOCKWAIT = 3'd3,
    LOCK     = 3'd4
  } state_t;

  // Faster levels need fewer 0.2 s ticks per row: {5,4,3,2} for levels 0..3.
  function automatic logic [TICK_W-1:0] level_thr(input logic [1:0] level);
    logic [TICK_W-1:0] thr;
    case (level)
      2'd0:    thr = 3'd5;
      2'd1:    thr = 3'd4;
      2'd2:    thr = 3'd3;
      default: thr = 3'd2;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/drop_scheduler.sv
// drop_scheduler: decides when the falling piece drops or locks, and
// restarts the 0.2 s tick timer after each completed action.
//
// Ports:
//   clk          in   system clock (50 MHz, shared with the tick timer)
//   rst          in   asynchronous active-low reset
//   sec          in   3-bit tick count from the timer
//   force_reset  out  zeroes the timer's sec on the next edge
//   enable       in   game running (low = paused)
//   level        in   speed level 0..3
//   soft_drop    in   down button, synchronized, level-sensitive
//   drop_req     out  request to move the piece down one row
//   drop_ack     in   one-cycle acknowledge of drop_req
//   drop_blocked in   with drop_ack: piece could not move down
//   lock_req     out  request to fix the piece into the board
//   lock_ack     in   one-cycle acknowledge of lock_req
//   stall        out  request outstanding while sec reached 7
module drop_scheduler
  import tetris_timing_pkg::*;
#(
  parameter int LOCK_TICKS = LOCK_TICKS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TICK_W-1:0] sec,
  output logic              force_reset,
  input  logic              enable,
  input  logic [1:0]        level,
  input  logic              soft_drop,
  output logic              drop_req,
  input  logic              drop_ack,
  input  logic              drop_blocked,
  output logic              lock_req,
  input  logic              lock_ack,
  output logic              stall
);

  localparam logic [TICK_W-1:0] LOCK_THR = LOCK_TICKS[TICK_W-1:0];

  state_t            r_state;
  logic              r_soft_q;
  logic              r_drop_req;
  logic              r_lock_req;
  logic              r_force_reset;
  logic              r_stall;

  state_t            w_next;
  logic [TICK_W-1:0] w_thr;
  logic              w_soft_rise;
  logic              w_at_thr;
  logic              w_lock_due;
  logic              w_drop_req_d;
  logic              w_lock_req_d;
  logic              w_force_reset_d;
  logic              w_stall_d;

  assign w_thr       = soft_drop ? 3'd1 : level_thr(level);
  assign w_soft_rise = soft_drop & ~r_soft_q;
  assign w_at_thr    = (sec >= w_thr);
  // While force_reset is high, sec still holds the pre-reset count; it only
  // reads 0 on the following cycle, so the lock compare waits one cycle.
  assign w_lock_due  = (sec >= LOCK_THR) & ~r_force_reset;

  // Next-state and next-output decode. Outputs are registered from the
  // next state so each one is high exactly while its state is current.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (enable && (w_at_thr || w_soft_rise)) w_next = REQ;
      REQ:      if (drop_ack) w_next = drop_blocked ? LOCKWAIT : CLR;
      CLR:      w_next = IDLE;
      LOCKWAIT: if (enable && (w_lock_due || w_soft_rise)) w_next = LOCK;
      LOCK:     if (lock_ack) w_next = CLR;
      default:  w_next = IDLE;
    endcase

    w_drop_req_d    = (w_next == REQ);
    w_lock_req_d    = (w_next == LOCK);
    // Pulse on CLR and LOCKWAIT entry; hold while paused in IDLE/LOCKWAIT.
    w_force_reset_d = (w_next == CLR)
                    | ((w_next == LOCKWAIT) && (r_state != LOCKWAIT))
                    | (((w_next == IDLE) || (w_next == LOCKWAIT)) && !enable);
    // Sticky while the same request stays outstanding; drops on leaving.
    w_stall_d       = (w_next == r_state)
                    && ((r_state == REQ) || (r_state == LOCK))
                    && (r_stall || (sec == 3'd7));
  end

  // State and output registers; reset drops every request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_soft_q      <= 1'b0;
      r_drop_req    <= 1'b0;
      r_lock_req    <= 1'b0;
      r_force_reset <= 1'b0;
      r_stall       <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_soft_q      <= soft_drop;
      r_drop_req    <= w_drop_req_d;
      r_lock_req    <= w_lock_req_d;
      r_force_reset <= w_force_reset_d;
      r_stall       <= w_stall_d;
    end
  end

  assign drop_req    = r_drop_req;
  assign lock_req    = r_lock_req;
  assign force_reset = r_force_reset;
  assign stall       = r_stall;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler. sec is driven by hand to mimic the
// tick timer (including its zeroing one cycle after force_reset).
// Expected outputs are packed as {drop_req, lock_req, force_reset, stall}.
module tb_drop_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sec = 3'd0;
  logic       force_reset;
  logic       enable = 1'b1;
  logic [1:0] level = 2'd0;
  logic       soft_drop = 1'b0;
  logic       drop_req;
  logic       drop_ack = 1'b0;
  logic       drop_blocked = 1'b0;
  logic       lock_req;
  logic       lock_ack = 1'b0;
  logic       stall;

  int total = 0;
  int bad   = 0;

  drop_scheduler #(.LOCK_TICKS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .sec          (sec),
    .force_reset  (force_reset),
    .enable       (enable),
    .level        (level),
    .soft_drop    (soft_drop),
    .drop_req     (drop_req),
    .drop_ack     (drop_ack),
    .drop_blocked (drop_blocked),
    .lock_req     (lock_req),
    .lock_ack     (lock_ack),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  // Drive one cycle of timer/handshake inputs, clock once, sample 1 ns later.
  task automatic applyStimulus(input logic [2:0] s, input logic dack,
                               input logic dblk, input logic lack);
    sec          = s;
    drop_ack     = dack;
    drop_blocked = dblk;
    lock_ack     = lack;
    @(posedge clk);
    #1;
    drop_ack     = 1'b0;
    drop_blocked = 1'b0;
    lock_ack     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {drop_req, lock_req, force_reset, stall};
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("reset", 4'b0000);
    rst = 1'b1;

    // Level 0: drop at sec=5, ack unblocked gives one-cycle force_reset
    for (int i = 0; i < 5; i++) applyStimulus(3'(i), 0, 0, 0);
    checkOutput("l0 below thr", 4'b0000);
    applyStimulus(3'd5, 0, 0, 0);
    checkOutput("l0 req at 5", 4'b1000);
    applyStimulus(3'd6, 0, 0, 0);
    checkOutput("l0 req held", 4'b1000);
    applyStimulus(3'd6, 1, 0, 0);
    checkOutput("l0 ack fr", 4'b0010);
    applyStimulus(3'd6, 0, 0, 0);
    checkOutput("l0 fr one cycle", 4'b0000);
    applyStimulus(3'd0, 1, 0, 1);
    checkOutput("stray acks", 4'b0000);

    // Level 3: request at sec=2, stall once sec reaches 7
    level = 2'd3;
    applyStimulus(3'd1, 0, 0, 0);
    checkOutput("l3 below thr", 4'b0000);
    applyStimulus(3'd2, 0, 0, 0);
    checkOutput("l3 req at 2", 4'b1000);
    for (int i = 3; i < 7; i++) applyStimulus(3'(i), 0, 0, 0);
    checkOutput("l3 no stall at 6", 4'b1000);
    applyStimulus(3'd7, 0, 0, 0);
    checkOutput("l3 stall", 4'b1001);
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("l3 stall sticky", 4'b1001);
    applyStimulus(3'd0, 1, 0, 0);
    checkOutput("l3 ack clears stall", 4'b0010);
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("l3 back idle", 4'b0000);

    // Soft drop: rise edge requests, held requests at sec=1, release restores
    level = 2'd0;
    soft_drop = 1'b1;
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("soft rise req", 4'b1000);
    applyStimulus(3'd0, 1, 0, 0);
    checkOutput("soft ack fr", 4'b0010);
    applyStimulus(3'd0, 0, 0, 0);
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("soft held sec0", 4'b0000);
    applyStimulus(3'd1, 0, 0, 0);
    checkOutput("soft held sec1", 4'b1000);
    applyStimulus(3'd1, 1, 0, 0);
    applyStimulus(3'd1, 0, 0, 0);
    soft_drop = 1'b0;
    applyStimulus(3'd0, 0, 0, 0);
    applyStimulus(3'd1, 0, 0, 0);
    checkOutput("soft released sec1", 4'b0000);
    applyStimulus(3'd4, 0, 0, 0);
    applyStimulus(3'd5, 0, 0, 0);
    checkOutput("soft released thr", 4'b1000);

    // Blocked drop: LOCKWAIT, lock_req at sec=3, lock_ack restarts timer
    applyStimulus(3'd5, 1, 1, 0);
    checkOutput("blocked fr", 4'b0010);
    applyStimulus(3'd5, 0, 0, 0);
    checkOutput("lockwait stale sec", 4'b0000);
    applyStimulus(3'd0, 0, 0, 0);
    applyStimulus(3'd1, 0, 0, 0);
    applyStimulus(3'd2, 0, 0, 0);
    checkOutput("lockwait sec2", 4'b0000);
    applyStimulus(3'd3, 0, 0, 0);
    checkOutput("lock at 3", 4'b0100);
    applyStimulus(3'd4, 1, 0, 0);
    checkOutput("drop_ack in lock", 4'b0100);
    applyStimulus(3'd4, 0, 0, 1);
    checkOutput("lock ack fr", 4'b0010);
    applyStimulus(3'd4, 0, 0, 0);
    checkOutput("lock done idle", 4'b0000);

    // Hard lock via soft rise in LOCKWAIT
    level = 2'd3;
    applyStimulus(3'd2, 0, 0, 0);
    applyStimulus(3'd2, 1, 1, 0);
    applyStimulus(3'd2, 0, 0, 0);
    applyStimulus(3'd0, 0, 0, 0);
    applyStimulus(3'd1, 0, 0, 0);
    checkOutput("lockwait sec1", 4'b0000);
    soft_drop = 1'b1;
    applyStimulus(3'd1, 0, 0, 0);
    checkOutput("hard lock", 4'b0100);
    soft_drop = 1'b0;
    applyStimulus(3'd1, 0, 0, 1);
    applyStimulus(3'd1, 0, 0, 0);
    checkOutput("hard lock done", 4'b0000);

    // Pause in IDLE: force_reset held, no requests
    enable = 1'b0;
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("pause fr", 4'b0010);
    applyStimulus(3'd3, 0, 0, 0);
    checkOutput("pause no req", 4'b0010);
    soft_drop = 1'b1;
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("pause soft ignored", 4'b0010);
    soft_drop = 1'b0;
    enable = 1'b1;
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("resume", 4'b0000);

    // Level change mid-count fires immediately
    level = 2'd0;
    applyStimulus(3'd3, 0, 0, 0);
    checkOutput("l0 at 3", 4'b0000);
    level = 2'd3;
    applyStimulus(3'd3, 0, 0, 0);
    checkOutput("level change", 4'b1000);

    // Asynchronous reset mid-handshake, then restart from IDLE
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset", 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("post reset idle", 4'b0000);
    applyStimulus(3'd2, 0, 0, 0);
    checkOutput("post reset req", 4'b1000);

    // Ack together with a soft rise: ack wins, no extra drop
    soft_drop = 1'b1;
    applyStimulus(3'd2, 1, 0, 0);
    checkOutput("ack+soft fr", 4'b0010);
    applyStimulus(3'd0, 0, 0, 0);
    applyStimulus(3'd0, 0, 0, 0);
    checkOutput("ack+soft no extra", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drop_scheduler.md
Name: drop_scheduler

Overview:
- Consumer and controller of the 0.2 s tick timer's `sec`/`forceReset` interface: the far end of that interface.
- Watches the timer's 3-bit tick count and decides when the falling Tetris piece must drop one row.
- Issues drop and lock requests to the game logic over req/ack handshakes.
- Restarts the timer by pulsing its force-reset input after each completed action.
- Sits between the tick timer and the board/game-state logic. Runs on the same 50 MHz clock as the timer.

Parameters:
- LOCK_TICKS, 3, sec ticks a blocked piece waits before lock is requested (3 = 0.6 s); legal range 1..6.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; asynchronous, active-low
- sec  in  3  tick count from the tick timer
- force_reset  out  1  to the timer's force-reset input; when high, the timer zeroes sec on the next edge
- enable  in  1  game running; low = paused
- level  in  2  speed level, index into the threshold table
- soft_drop  in  1  down button, already synchronized/debounced, level-sensitive
- drop_req  out  1  request: move piece down one row
- drop_ack  in  1  one-cycle acknowledge of drop_req
- drop_blocked  in  1  sampled only with drop_ack; 1 = piece could not move down
- lock_req  out  1  request: fix piece into board
- lock_ack  in  1  one-cycle acknowledge of lock_req
- stall  out  1  game logic has not answered for 7 ticks

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; drop_req, lock_req, force_reset and stall = 0; soft_drop history = 0.
- Threshold:
  - thr = soft_drop ? 1 : LEVEL_THR[level].
  - LEVEL_THR = {5,4,3,2} ticks, indexed by level 0..3.
  - Compare is unsigned 3-bit, sec >= thr.
- soft_rise = soft_drop & ~soft_drop_q, where soft_drop_q is a registered copy.
- States and outputs (all registered; outputs follow the state they belong to):
  - IDLE:
    - enable=0: force_reset held 1, freezing sec at 0; stay.
    - enable=1 and (sec>=thr or soft_rise): go to REQ. drop_req rises the cycle after the decision.
  - REQ:
    - drop_req=1 until the cycle drop_ack=1; drop_req is 0 the following cycle.
    - On ack with drop_blocked=0: go to CLR.
    - On ack with drop_blocked=1: go to LOCKWAIT.
    - enable is ignored while waiting.
  - CLR:
    - force_reset=1 for exactly one cycle, then IDLE.
    - Because of this pulse the timer restarts at 0 after every drop.
  - LOCKWAIT:
    - force_reset=1 on the entry cycle only.
    - Go to LOCK when sec >= LOCK_TICKS, or immediately on soft_rise (hard lock).
    - enable=0 holds force_reset=1 (pause) without leaving the state.
  - LOCK:
    - lock_req=1 until lock_ack; then one-cycle force_reset pulse (via CLR), then IDLE.
- Latency:
  - Threshold crossing to drop_req high: 1 cycle.
  - drop_ack to force_reset pulse: 1 cycle.
  - Timer shows sec=0 on the cycle after force_reset is high.
- stall:
  - Set while in REQ or LOCK and sec==7; cleared on leaving that state.
  - Prevents a silent 3-bit wrap from being missed. The request stays asserted; no retry or abort.
- Boundary conditions:
  - drop_ack and lock_ack outside their request state: ignored.
  - drop_ack together with soft_rise: ack wins; the soft edge is consumed, with no extra drop.
  - soft_drop held: after each drop sec restarts at 0, so a new request is issued every 1 tick (0.2 s).
  - level changes mid-count: the new threshold applies on the next cycle's compare. If sec already exceeds it, the request fires immediately.
  - sec wrap 7→0 while in IDLE: cannot occur with thr ≤ 5; no special handling.
  - Reset mid-handshake: all requests drop asynchronously, with no completion pulse.

Decomposition:
- Package `tetris_timing_pkg`:
  - state enum (IDLE, REQ, CLR, LOCKWAIT, LOCK).
  - LEVEL_THR table.
  - TICK_W=3.
  - Default LOCK_TICKS.
- No sub-module. The state machine, edge detector and comparator are small enough to live in one module.

Test Plan:
- Reset with level=0, enable=1, timer free-running: drop_req rises 1 cycle after sec=5. Ack with blocked=0 → force_reset high exactly 1 cycle, sec=0 next cycle.
- level=3: drop_req when sec=2. Hold drop_ack low until sec=7 → stall=1 and drop_req still 1. Ack → stall=0, force_reset pulse.
- Hold soft_drop from sec=0: request on the rise edge (1 cycle), then after each acked drop a new request at sec=1. Release: next request at LEVEL_THR.
- Ack with drop_blocked=1 → LOCKWAIT, force_reset pulse. lock_req rises when sec=3 (LOCK_TICKS=3). lock_ack → force_reset pulse, IDLE.
- In LOCKWAIT at sec=1, soft_drop rise → lock_req next cycle. Set enable=0 in IDLE → force_reset held 1, sec stays 0, no drop_req.
- Deassert rst while drop_req=1 → drop_req, lock_req and force_reset are 0 in the same cycle. After release, the block restarts from IDLE.
